// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 8;

endpackage

// File: rtl/fullAdder.sv
// Single-bit full adder shared across the codebase's serial datapaths.
module fullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: feeds one full adder LSB first, one bit per clock,
// behind a start/busy/done handshake.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int              CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic             busy_d;
    logic             done_d;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_next;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             last_bit;
    logic             fa_s;
    logic             fa_cout;

    fullAdder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign last_bit = (cnt == LAST_CNT);
    // New bit enters at the MSB; the concat-and-shift form stays legal at WIDTH=1.
    assign sum_next = WIDTH'({fa_s, sum_sh} >> 1);

    always_comb begin
        // NOTE: every variable driven here gets a default first so no path
        // through the case leaves it unassigned, which would infer a latch.
        next_state = state;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        case (state)
            IDLE:    if (start_i) next_state = RUN;
            RUN:     if (last_bit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        busy_d = (next_state != IDLE);
        done_d = (next_state == DONE);
    end

    // NOTE: reset is sampled on the clock edge (synchronous), so it lives
    // inside the clocked branch rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            state  <= next_state;
            busy_o <= busy_d;
            done_o <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_o  <= '0;
            cout_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        a_sh   <= a_i;
                        b_sh   <= b_i;
                        carry  <= cin_i;
                        cnt    <= '0;
                        sum_sh <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_next;
                    carry  <= fa_cout;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        sum_o  <= sum_next;
                        cout_o <= fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH 8, 4 and 1 with a result scoreboard.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;
    logic       start1, cin1, busy1, done1, cout1;
    logic       a1, b1, sum1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] q8[$];
    logic [32:0] q4[$];
    logic [32:0] q1[$];

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_i(start8), .a_i(a8), .b_i(b8), .cin_i(cin8),
        .busy_o(busy8), .done_o(done8), .sum_o(sum8), .cout_o(cout8)
    );
    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start_i(start4), .a_i(a4), .b_i(b4), .cin_i(cin4),
        .busy_o(busy4), .done_o(done4), .sum_o(sum4), .cout_o(cout4)
    );
    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .a_i(a1), .b_i(b1), .cin_i(cin1),
        .busy_o(busy1), .done_o(done1), .sum_o(sum1), .cout_o(cout1)
    );

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input int w, input logic [7:0] a, input logic [7:0] b,
                              input logic c, input logic s);
        case (w)
            8:       begin a8 = a;      b8 = b;      cin8 = c; start8 = s; end
            4:       begin a4 = a[3:0]; b4 = b[3:0]; cin4 = c; start4 = s; end
            default: begin a1 = a[0];   b1 = b[0];   cin1 = c; start1 = s; end
        endcase
    endtask

    function automatic logic busy_of(input int w);
        return (w == 8) ? busy8 : (w == 4) ? busy4 : busy1;
    endfunction

    function automatic logic done_of(input int w);
        return (w == 8) ? done8 : (w == 4) ? done4 : done1;
    endfunction

    task automatic push_exp(input int w, input logic [32:0] e);
        case (w)
            8:       q8.push_back(e);
            4:       q4.push_back(e);
            default: q1.push_back(e);
        endcase
    endtask

    task automatic pop_check(input int w, input logic [32:0] obs);
        logic [32:0] e;
        int sz;
        sz = (w == 8) ? q8.size() : (w == 4) ? q4.size() : q1.size();
        if (sz == 0) begin
            check($sformatf("spurious done w%0d", w), 33'd1, 33'd0);
        end else begin
            case (w)
                8:       e = q8.pop_front();
                4:       e = q4.pop_front();
                default: e = q1.pop_front();
            endcase
            check($sformatf("result w%0d", w), obs, e);
        end
    endtask

    // Scoreboard side: every done pulse retires the oldest expected result.
    always @(negedge clk) begin
        if (done8) pop_check(8, {24'b0, cout8, sum8});
        if (done4) pop_check(4, {28'b0, cout4, sum4});
        if (done1) pop_check(1, {31'b0, cout1, sum1});
    end

    // One full transaction: accept, measure latency and busy span, return to IDLE.
    task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic c);
        int lat = 0;
        int busy_cyc = 0;
        push_exp(w, 33'(a) + 33'(b) + 33'(c));
        set_inputs(w, a, b, c, 1'b1);
        tick();
        set_inputs(w, 8'hC3, 8'h5A, ~c, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy_of(w)) busy_cyc++;
            if (done_of(w)) begin
                lat = i;
                break;
            end
        end
        check($sformatf("latency w%0d", w), 33'(lat), 33'(w + 1));
        check($sformatf("busy span w%0d", w), 33'(busy_cyc), 33'(w + 1));
        tick();
        check($sformatf("idle after done w%0d", w), {32'b0, busy_of(w)}, 33'd0);
    endtask

    initial begin
        int first;
        int second;

        set_inputs(8, 8'h00, 8'h00, 1'b0, 1'b0);
        set_inputs(4, 8'h00, 8'h00, 1'b0, 1'b0);
        set_inputs(1, 8'h00, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        tick();
        check("reset busy8", {32'b0, busy8}, 33'd0);
        check("reset done8", {32'b0, done8}, 33'd0);
        check("reset sum8",  {25'b0, sum8},  33'd0);
        check("reset cout8", {32'b0, cout8}, 33'd0);
        check("reset busy4", {32'b0, busy4}, 33'd0);
        check("reset busy1", {32'b0, busy1}, 33'd0);
        rst_n = 1'b1;
        tick();

        run_op(8, 8'h5A, 8'h3C, 1'b0);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        tick();
        tick();
        check("sum8 held", {24'b0, cout8, sum8}, 33'h096);

        run_op(8, 8'hFF, 8'h01, 1'b0);
        run_op(8, 8'h00, 8'h00, 1'b1);

        // start held high; operands change mid-RUN and must only feed the follow-on op.
        a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back(33'h033);
        tick();
        repeat (3) @(posedge clk);
        #1;
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
        q8.push_back(33'h100);
        first = 0;
        second = 0;
        for (int i = 1; i <= 60 && second == 0; i++) begin
            @(negedge clk);
            if (done8) begin
                if (first == 0) first = i;
                else second = i;
            end
        end
        start8 = 1'b0;
        check("done spacing", 33'(second - first), 33'd10);
        tick();
        check("idle after back-to-back", {32'b0, busy8}, 33'd0);

        run_op(8, 8'hFF, 8'hFF, 1'b1);

        // Abort in the 4th RUN cycle with start also asserted on the reset edge.
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        start8 = 1'b1;
        tick();
        check("abort busy8", {32'b0, busy8}, 33'd0);
        check("abort done8", {32'b0, done8}, 33'd0);
        check("abort sum8",  {25'b0, sum8},  33'd0);
        check("abort cout8", {32'b0, cout8}, 33'd0);
        rst_n = 1'b1;
        start8 = 1'b0;
        tick();
        check("post-abort idle", {32'b0, busy8}, 33'd0);
        run_op(8, 8'h01, 8'h02, 1'b0);

        for (int ia = 0; ia < 2; ia++)
            for (int ib = 0; ib < 2; ib++)
                for (int ic = 0; ic < 2; ic++)
                    run_op(1, 8'(ia), 8'(ib), ic[0]);

        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int ic = 0; ic < 2; ic++)
                    run_op(4, 8'(ia), 8'(ib), ic[0]);

        tick();
        check("scoreboard drained w8", 33'(q8.size()), 33'd0);
        check("scoreboard drained w4", 33'(q4.size()), 33'd0);
        check("scoreboard drained w1", 33'(q1.size()), 33'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder controller. It sequences one instance of the team's single-bit full adder (ports a, b, cin, s, cout) over WIDTH-bit operands, LSB first, one bit per clock. Operands and the result travel through shift registers, and the carry is held in a flip-flop between bits. The block uses a start/busy/done handshake so a host FSM or testbench can issue additions without re-driving inputs bit by bit.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 1..32
CNT_W, $clog2(WIDTH)+1, bit-counter width; derived, never overridden

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
start_i  input  1  request; accepted only in IDLE
a_i  input  WIDTH  operand A; sampled on the accepting edge only
b_i  input  WIDTH  operand B; sampled on the accepting edge only
cin_i  input  1  carry-in; sampled on the accepting edge only
busy_o  output  1  high in RUN and DONE
done_o  output  1  one-cycle pulse; result valid
sum_o  output  WIDTH  result; held stable until the next accepted start
cout_o  output  1  final carry-out; held like sum_o

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n).
- Reset, when rst_n=0 at a rising edge:
  - state goes to IDLE.
  - busy_o=0, done_o=0, sum_o=0, cout_o=0.
  - Shift registers, carry flop and counter all clear to 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when start_i=1. On that edge:
    - a_sh<=a_i, b_sh<=b_i, carry<=cin_i, cnt<=0, sum_sh<=0.
  - RUN, every edge:
    - Full adder inputs: a=a_sh[0], b=b_sh[0], cin=carry.
    - sum_sh <= {s, sum_sh[WIDTH-1:1]}, so s enters the MSB and the register shifts right.
    - a_sh and b_sh shift right, zero-filled.
    - carry<=cout; cnt<=cnt+1.
    - When cnt==WIDTH-1, go to DONE and load sum_o<={s, sum_sh[WIDTH-1:1]} and cout_o<=cout.
  - DONE: done_o=1 for exactly this cycle, then IDLE unconditionally.
- Latency: start accepted at edge E0; RUN covers edges E1..E_WIDTH; done_o is high in the cycle after edge E_WIDTH. An operation therefore occupies WIDTH+1 cycles.
- Next start: a start_i in DONE is ignored. The earliest accepted start is the IDLE cycle that follows DONE. Repeat period is WIDTH+2 cycles.
- start_i while busy (RUN or DONE) is ignored. In-flight operands and the result are unaffected.
- a_i, b_i and cin_i may change freely after the accepting edge.
- sum_o and cout_o update only on the RUN->DONE edge.
- done_o, busy_o, sum_o and cout_o are all registered; there are no combinational paths from inputs to outputs.
- Arithmetic: {cout_o, sum_o} = a_i + b_i + cin_i, computed modulo 2^(WIDTH+1), with values taken at the accepting edge.
- WIDTH=1: RUN lasts exactly one cycle (cnt==0 == WIDTH-1 on the first RUN edge).
- Reset mid-operation (RUN or DONE):
  - Returns to IDLE on the reset edge and aborts the operation.
  - No done_o pulse; sum_o and cout_o clear to 0.
  - A start_i=1 on the reset edge is ignored. Reset has priority.

Decomposition:
- Shared package serial_adder_pkg holds:
  - state typedef: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - WIDTH default constant.
- Sub-module: the existing single-bit full adder (module fullAdder), instantiated once with named ports a, b, cin, s, cout.
- The controller holds all sequential logic: FSM, shift registers, carry flop and counter.

Test Plan:
- Default WIDTH=8: reset for 2 cycles -> busy_o=0, done_o=0, sum_o=0x00, cout_o=0.
- a=0x5A, b=0x3C, cin=0, start pulse -> done_o pulses exactly 9 cycles after the accepting edge, sum_o=0x96, cout_o=0; busy_o high for 9 cycles.
- Carry corners:
  - 0xFF+0x01, cin=0 -> sum_o=0x00, cout_o=1.
  - 0xFF+0xFF, cin=1 -> sum_o=0xFF, cout_o=1.
  - 0x00+0x00, cin=1 -> sum_o=0x01, cout_o=0.
- Interference during an operation:
  - Hold start_i=1 throughout and change a_i/b_i mid-RUN -> result reflects only the operands captured first.
  - The next operation starts on the IDLE cycle after DONE; done pulses are WIDTH+2 cycles apart.
- Reset mid-op: start 0x12+0x34, assert rst_n=0 at the 4th RUN cycle -> next cycle busy_o=0, no done_o, sum_o=0x00. A fresh 0x01+0x02 then yields 0x03.
- Exhaustive checks, all compared against a + b + cin:
  - WIDTH=1: all 8 input combinations -> done_o 2 cycles after start.
  - WIDTH=4: all 512 combinations.
